// File: rtl/launcher_pkg.sv
// Shared state encoding and default geometry for the core launcher.
package launcher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        RUN,
        DRAIN,
        FIN
    } launch_state_t;

    localparam int AW_DEF       = 8;
    localparam int N_IN_DEF     = 8;
    localparam int IN_BASE_DEF  = 0;
    localparam int N_OUT_DEF    = 4;
    localparam int OUT_BASE_DEF = 64;
    localparam int TW_DEF       = 16;
    localparam int TIMEOUT_DEF  = 4096;

endpackage

// File: rtl/launch_idx_ctr.sv
// Transfer index shared by the operand load and result drain phases.
// limit is one bit wider than the count so a full 2^AW transfer is expressible.
module launch_idx_ctr #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    input  logic [AW:0]   limit,
    output logic [AW-1:0] count,
    output logic          last
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + AW'(1);
        end
    end

    assign last = ({1'b0, count} == (limit - (AW+1)'(1)));

endmodule

// File: rtl/core_launcher.sv
// Host-side job launcher for the 8-bit core: load operands, kick, wait, drain results.
// Optional macro LAUNCH_CHECKSUM_EN adds XOR checksums of loaded and drained bytes.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// LOAD  | streaming operand bytes into data memory
// KICK  | core released, one-cycle req pulse
// RUN   | core running, counting cycles until done or timeout
// DRAIN | streaming result bytes out of data memory
// FIN   | one-cycle job_done pulse
module core_launcher
    import launcher_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int N_IN     = N_IN_DEF,
    parameter int IN_BASE  = IN_BASE_DEF,
    parameter int N_OUT    = N_OUT_DEF,
    parameter int OUT_BASE = OUT_BASE_DEF,
    parameter int TW       = TW_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wr_dat,
    input  logic [7:0]    mem_rd_dat,
    output logic          core_reset,
    output logic          core_req,
    input  logic          core_done,
    output logic          res_valid,
    output logic [7:0]    res_data,
    input  logic          res_ready,
    output logic          busy,
    output logic          job_done,
    output logic          timeout,
    output logic [TW-1:0] cycles
`ifdef LAUNCH_CHECKSUM_EN
    ,
    output logic [7:0]    in_csum,
    output logic [7:0]    out_csum
`endif
);

    localparam logic [AW:0]   N_IN_L     = (AW+1)'(N_IN);
    localparam logic [AW:0]   N_OUT_L    = (AW+1)'(N_OUT);
    localparam logic [AW-1:0] IN_BASE_A  = AW'(IN_BASE);
    localparam logic [AW-1:0] OUT_BASE_A = AW'(OUT_BASE);
    localparam logic [TW:0]   TIMEOUT_L  = (TW+1)'(TIMEOUT);

    launch_state_t state_q, state_d;

    logic          ctr_clear;
    logic          ctr_inc;
    logic [AW:0]   ctr_limit;
    logic [AW-1:0] idx;
    logic          idx_last;
    logic          run_expire;
    logic          start_acc;
    logic          ld_acc;
    logic          rd_acc;

    launch_idx_ctr #(.AW(AW)) u_idx (
        .clk   (clk),
        .reset (reset),
        .clear (ctr_clear),
        .inc   (ctr_inc),
        .limit (ctr_limit),
        .count (idx),
        .last  (idx_last)
    );

    // Compare one bit wider so TIMEOUT close to 2^TW cannot alias through wrap.
    assign run_expire = (({1'b0, cycles} + (TW+1)'(1)) == TIMEOUT_L);
    assign start_acc  = (state_q == IDLE) && start;
    assign ld_acc     = (state_q == LOAD) && ld_valid;
    assign rd_acc     = (state_q == DRAIN) && res_ready;

    always_comb begin
        state_d    = state_q;
        ld_ready   = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_wr_dat = '0;
        core_reset = 1'b1;
        core_req   = 1'b0;
        res_valid  = 1'b0;
        res_data   = '0;
        job_done   = 1'b0;
        ctr_clear  = 1'b0;
        ctr_inc    = 1'b0;
        ctr_limit  = N_IN_L;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    ctr_clear = 1'b1;
                end
            end
            LOAD: begin
                ld_ready   = 1'b1;
                mem_addr   = IN_BASE_A + idx;
                mem_wr_dat = ld_data;
                mem_wr_en  = ld_valid;
                if (ld_valid) begin
                    ctr_inc = 1'b1;
                    if (idx_last) begin
                        ctr_clear = 1'b1;
                        state_d   = KICK;
                    end
                end
            end
            KICK: begin
                core_reset = 1'b0;
                core_req   = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                core_reset = 1'b0;
                if (core_done) begin
                    state_d = DRAIN;
                end else if (run_expire) begin
                    state_d = FIN;
                end
            end
            DRAIN: begin
                ctr_limit = N_OUT_L;
                mem_addr  = OUT_BASE_A + idx;
                res_valid = 1'b1;
                // Address only moves on accept, so read data is stable under stall.
                res_data  = mem_rd_dat;
                if (res_ready) begin
                    ctr_inc = 1'b1;
                    if (idx_last) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                job_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cycles  <= '0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                timeout <= 1'b0;
            end
            if (state_q == KICK) begin
                cycles <= '0;
            end
            if (state_q == RUN) begin
                cycles <= cycles + TW'(1);
                if (!core_done && run_expire) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

`ifdef LAUNCH_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            in_csum  <= '0;
            out_csum <= '0;
        end else begin
            if (ld_acc) begin
                in_csum <= in_csum ^ ld_data;
            end
            if (rd_acc) begin
                out_csum <= out_csum ^ mem_rd_dat;
            end
        end
    end
`else
    logic unused_acc;
    assign unused_acc = ld_acc ^ rd_acc;
`endif

endmodule

// File: tb/tb_core_launcher.sv
// Self-checking bench for core_launcher: job-level model, memory and core stand-ins.
// Optional macro LAUNCH_CHECKSUM_EN also checks the checksum outputs.
module tb_core_launcher;

    localparam int N_IN     = 8;
    localparam int IN_BASE  = 0;
    localparam int N_OUT    = 4;
    localparam int OUT_BASE = 64;
    localparam int TIMEOUT  = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic        ld_ready;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wr_dat;
    logic [7:0]  mem_rd_dat;
    logic        core_reset;
    logic        core_req;
    logic        core_done = 1'b0;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_ready = 1'b0;
    logic        busy;
    logic        job_done;
    logic        timeout;
    logic [15:0] cycles;
`ifdef LAUNCH_CHECKSUM_EN
    logic [7:0]  in_csum;
    logic [7:0]  out_csum;
`endif

    core_launcher dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wr_dat (mem_wr_dat),
        .mem_rd_dat (mem_rd_dat),
        .core_reset (core_reset),
        .core_req   (core_req),
        .core_done  (core_done),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .busy       (busy),
        .job_done   (job_done),
        .timeout    (timeout),
        .cycles     (cycles)
`ifdef LAUNCH_CHECKSUM_EN
        ,
        .in_csum    (in_csum),
        .out_csum   (out_csum)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Data memory: combinational read, write on the low phase when strobed.
    logic [7:0] mem [256];
    int wr_log[$];
    assign mem_rd_dat = mem[mem_addr];

    always @(negedge clk) begin
        if (chk_on && mem_wr_en === 1'b1) begin
            mem[mem_addr] = mem_wr_dat;
            wr_log.push_back(int'(mem_addr));
        end
    end

    // Core stand-in: done is seen in the done_delay-th cycle after the req cycle.
    int done_delay = 0;
    int run_ctr = 0;
    always @(negedge clk) begin
        if (core_req === 1'b1) run_ctr = 1;
        else if (run_ctr > 0) run_ctr++;
        core_done = (done_delay != 0) && (run_ctr == done_delay + 1);
    end

    // Job model. ph: 0 idle, 1 loading, 2 kick, 3 running, 4 draining, 5 finish.
    int ph = 0;
    int m_ld = 0, m_dr = 0, m_cyc = 0;
    bit m_to = 1'b0;
    logic [7:0] m_in_cs = 8'h00, m_out_cs = 8'h00;

    always @(posedge clk) begin
        if (reset) begin
            ph = 0; m_ld = 0; m_dr = 0; m_cyc = 0; m_to = 1'b0;
            m_in_cs = 8'h00; m_out_cs = 8'h00;
        end else begin
            case (ph)
                0: if (start) begin
                    ph = 1; m_ld = 0; m_dr = 0; m_to = 1'b0;
                    m_in_cs = 8'h00; m_out_cs = 8'h00;
                end
                1: if (ld_valid) begin
                    m_in_cs ^= ld_data;
                    m_ld++;
                    if (m_ld == N_IN) ph = 2;
                end
                2: begin m_cyc = 0; ph = 3; end
                3: begin
                    m_cyc++;
                    if (core_done) ph = 4;
                    else if (m_cyc == TIMEOUT) begin m_to = 1'b1; ph = 5; end
                end
                4: if (res_ready) begin
                    m_out_cs ^= mem[(OUT_BASE + m_dr) % 256];
                    m_dr++;
                    if (m_dr == N_OUT) ph = 5;
                end
                default: ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        int a;
        if (chk_on) begin
            a = (ph == 1) ? (IN_BASE + m_ld) % 256 : (ph == 4) ? (OUT_BASE + m_dr) % 256 : 0;
            chk("busy", busy, ph != 0);
            chk("ld_ready", ld_ready, ph == 1);
            chk("mem_wr_en", mem_wr_en, (ph == 1) && ld_valid);
            chk("mem_addr", mem_addr, a);
            if (ph == 1 && ld_valid) chk("mem_wr_dat", mem_wr_dat, ld_data);
            chk("core_reset", core_reset, !(ph == 2 || ph == 3));
            chk("core_req", core_req, ph == 2);
            chk("res_valid", res_valid, ph == 4);
            if (ph == 4) chk("res_data", res_data, mem[a]);
            chk("job_done", job_done, ph == 5);
            chk("timeout", timeout, m_to);
            chk("cycles", cycles, m_cyc);
`ifdef LAUNCH_CHECKSUM_EN
            chk("in_csum", in_csum, m_in_cs);
            chk("out_csum", out_csum, m_out_cs);
`endif
        end
    end

    int j_req, j_done, j_rv, j_lat, j_cyc;
    bit j_to;
    logic [7:0] res_q[$];

    task automatic run_job(input bit gap, input int delay, input bit rtoggle, input bit abuse);
        bit fin;
        int k;
        fin = 1'b0; k = 0;
        done_delay = delay;
        res_q.delete();
        j_req = 0; j_done = 0; j_rv = 0; j_lat = -1; j_cyc = -1; j_to = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 6000 && !fin; c++) begin
            ld_valid  = (k < N_IN) && (!gap || (c % 2 == 1));
            ld_data   = 8'(17 * (k + 1));
            res_ready = !rtoggle || (c % 2 == 0);
            start     = abuse && (c == 15);
            @(negedge clk);
            if (ld_valid && ld_ready === 1'b1) k++;
            if (core_req === 1'b1) j_req++;
            if (res_valid === 1'b1) begin
                j_rv++;
                if (res_ready) res_q.push_back(res_data);
            end
            if (job_done === 1'b1) begin
                j_done++; j_lat = c + 1; j_cyc = int'(cycles); j_to = timeout; fin = 1'b1;
            end
            step();
        end
        ld_valid = 1'b0; start = 1'b0; res_ready = 1'b0;
        chk("job_end_bound", fin, 1);
        @(negedge clk);
        if (job_done === 1'b1) j_done++;
        step();
    endtask

    task automatic check_loads(input string tag);
        chk({tag, "_wr_cnt"}, wr_log.size(), N_IN);
        for (int i = 0; i < N_IN && i < wr_log.size(); i++)
            chk({tag, "_wr_addr"}, wr_log[i], IN_BASE + i);
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_res_cnt"}, res_q.size(), N_OUT);
        for (int i = 0; i < N_OUT && i < res_q.size(); i++)
            chk({tag, "_res"}, res_q[i], 8'hA0 + 8'(i));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < N_OUT; i++) mem[OUT_BASE + i] = 8'hA0 + 8'(i);

        // Reset
        reset = 1'b1;
        step();
        chk_on = 1'b1;
        step();
        @(negedge clk);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_timeout", timeout, 0);
        step();
        reset = 1'b0;
        step();

        // Streaming load, done after 10 cycles, no backpressure
        wr_log.delete();
        run_job(1'b0, 10, 1'b0, 1'b0);
        check_loads("stream");
        for (int i = 0; i < N_IN; i++) chk("stream_mem", mem[IN_BASE + i], 8'h11 * 8'(i + 1));
        chk("stream_req_cnt", j_req, 1);
        chk("stream_done_cnt", j_done, 1);
        chk("stream_latency", j_lat, 25);
        chk("stream_cycles", j_cyc, 10);
        check_results("stream");
`ifdef LAUNCH_CHECKSUM_EN
        chk("stream_in_csum", in_csum, 8'h88);
        chk("stream_out_csum", out_csum, 8'h00);
`endif

        // Gapped load, toggling result backpressure
        wr_log.delete();
        run_job(1'b1, 10, 1'b1, 1'b0);
        check_loads("gap");
        chk("gap_req_cnt", j_req, 1);
        chk("gap_done_cnt", j_done, 1);
        chk("gap_cycles", j_cyc, 10);
        check_results("gap");

        // Core never finishes
        run_job(1'b0, 0, 1'b0, 1'b0);
        chk("to_cycles", j_cyc, 4096);
        chk("to_flag", j_to, 1);
        chk("to_res_valid_cnt", j_rv, 0);
        chk("to_done_cnt", j_done, 1);
        @(negedge clk);
        chk("to_busy_after", busy, 0);
        chk("to_sticky", timeout, 1);
        step();

        // start pulsed while running must not restart anything
        run_job(1'b0, 5, 1'b0, 1'b1);
        chk("abuse_cycles", j_cyc, 5);
        chk("abuse_to_clear", j_to, 0);
        chk("abuse_done_cnt", j_done, 1);
        check_results("abuse");
        repeat (3) step();
        @(negedge clk);
        chk("abuse_idle", busy, 0);
        step();

        // Reset after three operand bytes
        start = 1'b1;
        step();
        start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_data = 8'(17 * (i + 1));
            step();
        end
        ld_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_core_reset", core_reset, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_ld_ready", ld_ready, 0);
        step();
        wr_log.delete();
        run_job(1'b0, 3, 1'b0, 1'b0);
        check_loads("reload");
        chk("reload_cycles", j_cyc, 3);
        check_results("reload");

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
